// File: rtl/mem_arb_if_if.sv
// Bus bundle between the requester channels, the arbiter and the SRAM port.
// slave is the arbiter's view; master is the view of whatever drives the requests and the SRAM response.
interface mem_arb_if_if #(
  parameter int NCH = 2,
  parameter int AW  = 14,
  parameter int DW  = 16
);
  logic [NCH-1:0]    store;
  logic [NCH-1:0]    load;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;
  logic [NCH-1:0]    done;
  logic              err;
  logic [DW-1:0]     rdata;
  logic              mem_we;
  logic              mem_re;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_resp;

  modport slave (
    input  store, load, addr, wdata, mem_rdata, mem_resp,
    output done, err, rdata, mem_we, mem_re, mem_addr, mem_wdata
  );

  modport master (
    output store, load, addr, wdata, mem_rdata, mem_resp,
    input  done, err, rdata, mem_we, mem_re, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_if.sv
// Round-robin arbiter that gives NCH requesters single-access use of one SRAM port,
// with a response timeout and an error completion for channels requesting store and load together.
module mem_arb_if #(
  parameter int NCH = 2,
  parameter int AW  = 14,
  parameter int DW  = 16,
  parameter int TMO = 15
) (
  input logic         clk,
  input logic         reset,
  mem_arb_if_if.slave bus
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE, ERR} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [NCH-1:0] req;
  logic [NCH-1:0] done_c;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  grant_q;
  logic [IW-1:0]  pick;
  logic [IW-1:0]  idx;
  logic           found;
  logic           op_store;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  rdata_q;
  logic [7:0]     wait_cnt;
  logic           err_c;
  logic           we_c;
  logic           re_c;

  assign req = bus.store | bus.load;

  // First requesting channel at or after rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = IW'((int'(rr_ptr) + i) % NCH);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A response in the last allowed wait cycle still completes normally.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (found) begin
          if (bus.store[pick] && bus.load[pick]) state_nxt = ERR;
          else                                   state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_resp)                     state_nxt = DONE;
        else if (wait_cnt == 8'(TMO - 1))     state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done_c = '0;
    err_c  = 1'b0;
    we_c   = 1'b0;
    re_c   = 1'b0;
    case (state)
      ISSUE: begin
        we_c = op_store;
        re_c = !op_store;
      end
      DONE: done_c[grant_q] = 1'b1;
      ERR: begin
        done_c[grant_q] = 1'b1;
        err_c           = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      grant_q  <= '0;
      op_store <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == IDLE && found) begin
        grant_q  <= pick;
        op_store <= bus.store[pick];
        addr_q   <= bus.addr[pick*AW +: AW];
        wdata_q  <= bus.wdata[pick*DW +: DW];
        wait_cnt <= '0;
        if (int'(pick) == NCH - 1) rr_ptr <= '0;
        else                       rr_ptr <= pick + 1'b1;
      end
      if (state == ISSUE && !bus.mem_resp) wait_cnt <= wait_cnt + 8'd1;
      if (state == ISSUE && bus.mem_resp && !op_store) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.done      = done_c;
  assign bus.err       = err_c;
  assign bus.rdata     = rdata_q;
  assign bus.mem_we    = we_c;
  assign bus.mem_re    = re_c;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule
